axi_slave_write_responder: RTL and testbench

AXI3 write-side slave responder: accepts a write address on AW, absorbs the data burst on W into an internal byte-addressed memory under WSTRB, and returns a single B response. It is the responder end of the write path driven by the master in `AXI_top_design`. It is instantiated alongside the `axi` interface in the bench so that master-initiated bursts can be checked against memory contents.

---
 rtl/axi_slave_write_responder.sv | 116 +++++++++++
 tb/tb_axi_slave_write_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_write_responder.sv
// axi_slave_write_responder: AXI3 write slave that absorbs bursts into a byte memory and returns one B response.
// Define AXI_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP bursts are consumed and answered with SLVERR.
module axi_slave_write_responder #(
  parameter int WIDTH = 32,
  parameter int SIZE = 3,
  parameter int MEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [WIDTH/8-1:0] AWID,
  input  logic [WIDTH-1:0]   AWADDR,
  input  logic [WIDTH/8-1:0] AWLEN,
  input  logic [SIZE-1:0]    AWSIZE,
  input  logic [SIZE-2:0]    AWBURST,
  input  logic               WVALID,
  output logic               WREADY,
  input  logic [WIDTH/8-1:0] WID,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH/8-1:0] WSTRB,
  input  logic               WLAST,
  output logic               BVALID,
  input  logic               BREADY,
  output logic [WIDTH/8-1:0] BID,
  output logic [SIZE-2:0]    BRESP,
  input  logic [WIDTH-1:0]   dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);
  localparam int NB = WIDTH / 8;
  localparam int AB = $clog2(MEM_BYTES);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state;
  logic [NB-1:0] id, len, cnt;
  logic [WIDTH-1:0] addr, step, base, next_addr, wrap_addr;
  logic [SIZE-1:0] size;
  logic [SIZE-2:0] burst;
  logic err, nowr, wrap_bad, aw_bad, last, oob, beat_err, w_hs;
  logic [7:0] mem [MEM_BYTES];
  assign step = WIDTH'(1) << size;
  assign base = {addr[WIDTH-1:2], 2'b00};
  assign last = cnt == len;
  assign w_hs = WVALID && WREADY;
  assign oob = |WSTRB && base >= WIDTH'(MEM_BYTES);
  assign beat_err = WID != id || WLAST != last || (oob && !nowr);
  assign next_addr = burst == 2'b00 ? addr : burst == 2'b01 ? addr + step : wrap_addr;
`ifdef AXI_WRAP_BURST_EN
  logic [WIDTH-1:0] span;
  assign span = (WIDTH'(len) + WIDTH'(1)) << size;
  assign wrap_addr = (addr & ~(span - WIDTH'(1))) | ((addr + step) & (span - WIDTH'(1)));
  assign wrap_bad = !(AWLEN inside {1, 3, 7, 15}) || (AWADDR & ((WIDTH'(1) << AWSIZE) - WIDTH'(1))) != '0;
`else
  assign wrap_addr = addr;
  assign wrap_bad = 1'b1;
`endif
  // Bursts flagged bad at AW time are consumed but never touch memory.
  assign aw_bad = AWSIZE > SIZE'(2) || AWBURST == 2'b11 || (AWBURST == 2'b10 && wrap_bad);
  assign dbg_data = dbg_addr < WIDTH'(MEM_BYTES) ?
    {mem[{dbg_addr[AB-1:2], 2'd3}], mem[{dbg_addr[AB-1:2], 2'd2}],
     mem[{dbg_addr[AB-1:2], 2'd1}], mem[{dbg_addr[AB-1:2], 2'd0}]} : '0;
  always_ff @(posedge clk)
    if (w_hs && !nowr && base < WIDTH'(MEM_BYTES))
      for (int i = 0; i < NB; i++)
        if (WSTRB[i]) mem[{base[AB-1:2], 2'(i)}] <= WDATA[8*i +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BID <= '0;
      BRESP <= '0;
      id <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      size <= '0;
      burst <= '0;
      err <= 1'b0;
      nowr <= 1'b0;
    end else case (state)
      IDLE: begin
        AWREADY <= !(AWVALID && AWREADY);
        if (AWVALID && AWREADY) begin
          id <= AWID;
          addr <= AWADDR;
          len <= AWLEN;
          size <= AWSIZE;
          burst <= AWBURST;
          err <= aw_bad;
          nowr <= aw_bad;
          cnt <= '0;
          WREADY <= 1'b1;
          state <= DATA;
        end
      end
      DATA: if (w_hs) begin
        addr <= next_addr;
        cnt <= cnt + 1'b1;
        err <= err || beat_err;
        if (last) begin
          state <= RESP;
          WREADY <= 1'b0;
          BVALID <= 1'b1;
          BID <= id;
          BRESP <= (err || beat_err) ? 2'b10 : 2'b00;
        end
      end
      RESP: if (BREADY) begin
        state <= IDLE;
        BVALID <= 1'b0;
        AWREADY <= 1'b1;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_axi_slave_write_responder.sv
// tb_axi_slave_write_responder: table-driven and randomized bursts checked against a byte-level memory model.
module tb_axi_slave_write_responder;
  logic clk = 0, resetn = 0;
  logic AWVALID = 0, AWREADY, WVALID = 0, WREADY, WLAST = 0, BVALID, BREADY = 0;
  logic [3:0] AWID = 0, AWLEN = 0, WID = 0, WSTRB = 0, BID;
  logic [31:0] AWADDR = 0, WDATA = 0, dbg_addr = 0, dbg_data;
  logic [2:0] AWSIZE = 0;
  logic [1:0] AWBURST = 0, BRESP;
  int checks = 0, errors = 0;

  axi_slave_write_responder dut (
    .clk(clk), .resetn(resetn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] mm [4096];
  bit mk [4096];
  logic [31:0] touched [$];
  logic [3:0] m_id;
  logic [31:0] m_addr;
  int m_len, m_size, m_burst, m_cnt;
  bit m_bad, m_err;

  function automatic void model_aw(input logic [3:0] id, input logic [31:0] addr, input int len, input int size, input int burst);
    bit wrap_ok;
`ifdef AXI_WRAP_BURST_EN
    wrap_ok = (len == 1 || len == 3 || len == 7 || len == 15) && (addr % (32'd1 << size)) == 0;
`else
    wrap_ok = 0;
`endif
    m_id = id; m_addr = addr; m_len = len; m_size = size; m_burst = burst; m_cnt = 0;
    m_bad = size > 2 || burst == 3 || (burst == 2 && !wrap_ok);
    m_err = m_bad;
  endfunction

  function automatic void model_beat(input logic [3:0] wid, input logic [31:0] data, input logic [3:0] strb, input logic wlast);
    longint b, step, span, start;
    if (wid != m_id) m_err = 1;
    if (wlast != (m_cnt == m_len)) m_err = 1;
    b = longint'(m_addr) - longint'(m_addr % 4);
    for (int i = 0; i < 4; i++)
      if (strb[i]) begin
        if (b + i >= 4096) m_err = 1;
        else if (!m_bad) begin mm[b+i] = data[8*i +: 8]; mk[b+i] = 1; end
      end
    if (!m_bad && b < 4096 && strb != 0) touched.push_back(32'(b));
    step = longint'(1) << m_size;
    if (!m_bad) begin
      if (m_burst == 1) m_addr = m_addr + 32'(step);
      else if (m_burst == 2) begin
        span = longint'(m_len + 1) * step;
        start = longint'(m_addr) - longint'(m_addr) % span;
        m_addr = 32'(start + (longint'(m_addr) - start + step) % span);
      end
    end
    m_cnt++;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_mem();
    logic [31:0] e, m, a;
    foreach (touched[j]) begin
      a = touched[j]; e = 0; m = 0;
      for (int i = 0; i < 4; i++)
        if (mk[a+i]) begin e[8*i +: 8] = mm[a+i]; m[8*i +: 8] = 8'hFF; end
      dbg_addr = a; #1;
      if (m != 0) chk("mem", dbg_data & m, e);
    end
    touched.delete();
    @(negedge clk);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    dbg_addr = a; #1; d = dbg_data;
  endtask

  logic [31:0] bd [16];
  logic [3:0] bs [16], bw [16];
  logic bl [16];

  function automatic logic [31:0] pat(input int k, input int b);
    return 32'h11111111 * 32'(b + 1) ^ (32'(k) << 28);
  endfunction

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall, input bit gaps, output logic [1:0] got);
    int t;
    logic [1:0] r;
    got = 2'bxx;
    model_aw(id, addr, int'(len), int'(size), int'(burst));
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1;
    t = 0;
    while (!AWREADY && t < 20) begin @(negedge clk); t++; end
    if (!AWREADY) begin chk("aw_timeout", AWREADY, 1); AWVALID = 0; return; end
    @(negedge clk);
    AWVALID = 0;
    chk("wready_after_aw", WREADY, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin WVALID = 0; @(negedge clk); end
      WVALID = 1; WID = bw[b]; WDATA = bd[b]; WSTRB = bs[b]; WLAST = bl[b];
      t = 0;
      while (!WREADY && t < 20) begin @(negedge clk); t++; end
      if (!WREADY) begin chk("w_timeout", WREADY, 1); WVALID = 0; return; end
      model_beat(bw[b], bd[b], bs[b], bl[b]);
      @(negedge clk);
    end
    WVALID = 0; WLAST = 0;
    r = m_err ? 2'b10 : 2'b00;
    chk("bvalid_latency", BVALID, 1);
    chk("bresp", BRESP, r);
    chk("bid", BID, id);
    got = BRESP;
    repeat (stall) begin
      @(negedge clk);
      chk("bvalid_hold", BVALID, 1);
      chk("bid_hold", BID, id);
      chk("bresp_hold", BRESP, r);
    end
    BREADY = 1;
    @(negedge clk);
    BREADY = 0;
    chk("bvalid_drop", BVALID, 0);
    chk("awready_after_b", AWREADY, 1);
    check_mem();
  endtask

  typedef struct {
    logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [1:0] burst;
    logic [3:0] strb; logic [3:0] wid; int lerr; logic [1:0] resp;
  } vec_t;
  vec_t tbl [10];
`ifdef AXI_WRAP_BURST_EN
  localparam logic [1:0] WRAP_RESP = 2'b00;
`else
  localparam logic [1:0] WRAP_RESP = 2'b10;
`endif

  initial begin
    logic [1:0] got;
    logic [31:0] d;
    int len, sz, bu;
    logic [31:0] a;
    logic [3:0] id;
    bit bad_id;
    int lerr;
    tbl[0] = '{4'd5, 32'h100, 4'd3, 3'd2, 2'd1, 4'hF, 4'd5, -1, 2'b00};
    tbl[1] = '{4'd1, 32'hFFC, 4'd1, 3'd2, 2'd1, 4'hF, 4'd1, -1, 2'b10};
    tbl[2] = '{4'd2, 32'h300, 4'd3, 3'd2, 2'd1, 4'hF, 4'd2, 1, 2'b10};
    tbl[3] = '{4'd2, 32'h340, 4'd3, 3'd2, 2'd1, 4'hF, 4'd3, -1, 2'b10};
    tbl[4] = '{4'd3, 32'h030, 4'd3, 3'd2, 2'd1, 4'hF, 4'd3, -1, 2'b00};
    tbl[5] = '{4'd4, 32'h038, 4'd3, 3'd2, 2'd2, 4'hF, 4'd4, -1, WRAP_RESP};
    tbl[6] = '{4'd6, 32'h400, 4'd2, 3'd2, 2'd0, 4'hF, 4'd6, -1, 2'b00};
    tbl[7] = '{4'd7, 32'h440, 4'd1, 3'd3, 2'd1, 4'hF, 4'd7, -1, 2'b10};
    tbl[8] = '{4'd8, 32'h480, 4'd1, 3'd2, 2'd3, 4'hF, 4'd8, -1, 2'b10};
    tbl[9] = '{4'd9, 32'h501, 4'd3, 3'd0, 2'd1, 4'h3, 4'd9, -1, 2'b00};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP}, 0);
    resetn = 1;
    chk("awready_before_edge", AWREADY, 0);
    @(negedge clk);
    chk("awready_after_release", AWREADY, 1);

    WVALID = 1;
    repeat (3) begin chk("wready_idle", WREADY, 0); @(negedge clk); end
    WVALID = 0;

    for (int k = 0; k < 10; k++) begin
      for (int b = 0; b < 16; b++) begin
        bd[b] = pat(k, b); bs[b] = tbl[k].strb; bw[b] = tbl[k].wid;
        bl[b] = b == int'(tbl[k].len) || b == tbl[k].lerr;
      end
      run_burst(tbl[k].id, tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, k % 3, 0, got);
      chk($sformatf("tbl%0d_resp", k), got, tbl[k].resp);
    end

    peek(32'h100, d); chk("incr_0x100", d, 32'h11111111);
    peek(32'h104, d); chk("incr_0x104", d, 32'h22222222);
    peek(32'h108, d); chk("incr_0x108", d, 32'h33333333);
    peek(32'h10C, d); chk("incr_0x10c", d, 32'h44444444);
    peek(32'hFFC, d); chk("oob_beat0", d, pat(1, 0));
    peek(32'h1000, d); chk("oob_peek_zero", d, 0);
    peek(32'h400, d); chk("fixed_last", d, pat(6, 2));
`ifdef AXI_WRAP_BURST_EN
    peek(32'h38, d); chk("wrap_0x38", d, pat(5, 0));
    peek(32'h30, d); chk("wrap_0x30", d, pat(5, 2));
`else
    peek(32'h38, d); chk("wrap_off_0x38", d, pat(4, 2));
    peek(32'h30, d); chk("wrap_off_0x30", d, pat(4, 0));
`endif
    @(negedge clk);

    bd[0] = 32'hAABBCCDD; bs[0] = 4'hF; bw[0] = 4'd1; bl[0] = 1;
    run_burst(4'd1, 32'h200, 4'd0, 3'd2, 2'd1, 0, 0, got);
    bd[0] = 32'h12345678; bs[0] = 4'b0101;
    run_burst(4'd1, 32'h200, 4'd0, 3'd2, 2'd1, 0, 0, got);
    chk("partial_resp", got, 2'b00);
    peek(32'h200, d); chk("partial_strobe", d, 32'hAA34CC78);
    @(negedge clk);

    for (int b = 0; b < 16; b++) begin bd[b] = pat(11, b); bs[b] = 4'hF; bw[b] = 4'd7; bl[b] = b == 1; end
    run_burst(4'd7, 32'h700, 4'd1, 3'd2, 2'd1, 5, 0, got);
    model_aw(4'd9, 32'h600, 3, 2, 1);
    AWID = 4'd9; AWADDR = 32'h600; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1;
    for (int t = 0; t < 20 && !AWREADY; t++) @(negedge clk);
    chk("rst_seq_awready", AWREADY, 1);
    @(negedge clk);
    AWVALID = 0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1; WID = 4'd9; WDATA = pat(12, b); WSTRB = 4'hF; WLAST = 0;
      for (int t = 0; t < 20 && !WREADY; t++) @(negedge clk);
      chk("rst_seq_wready", WREADY, 1);
      model_beat(4'd9, pat(12, b), 4'hF, 1'b0);
      @(negedge clk);
    end
    WDATA = pat(12, 2);
    #2 resetn = 0;
    #1 chk("midburst_reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP}, 0);
    WVALID = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    chk("rerelease_awready", AWREADY, 0);
    @(negedge clk);
    chk("rerelease_awready_up", AWREADY, 1);
    check_mem();
    for (int b = 0; b < 16; b++) begin bd[b] = pat(13, b); bs[b] = 4'hF; bw[b] = 4'd10; bl[b] = b == 3; end
    run_burst(4'd10, 32'h600, 4'd3, 3'd2, 2'd1, 1, 0, got);
    chk("post_reset_resp", got, 2'b00);

    for (int n = 0; n < 40; n++) begin
      sz = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
      bu = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
      len = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0: a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        1: a = 32'hFC0 + 32'($urandom_range(0, 63));
        default: a = 32'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 1);
      id = 4'($urandom);
      bad_id = $urandom_range(0, 7) == 0;
      lerr = $urandom_range(0, 7) == 0 ? $urandom_range(0, 15) : -1;
      for (int b = 0; b < 16; b++) begin
        bd[b] = $urandom; bs[b] = 4'($urandom);
        bw[b] = (bad_id && b == len / 2) ? id ^ 4'h1 : id;
        bl[b] = (b == len) ^ (b == lerr);
      end
      run_burst(id, a, 4'(len), 3'(sz), 2'(bu), $urandom_range(0, 2), 1, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
